// File: rtl/minsec_counter_if.sv
// Signal bundle between the minutes/seconds counter and its tick source / display consumer.
// The master drives the tick and control levels; the slave (the counter) returns BCD digits and strobes.
interface minsec_counter_if;
  logic       tick_in;
  logic       run;
  logic       clear;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       sec_pulse;
  logic       wrap_pulse;

  modport master (
    output tick_in, run, clear,
    input  sec_ones, sec_tens, min_ones, min_tens, sec_pulse, wrap_pulse
  );

  modport slave (
    input  tick_in, run, clear,
    output sec_ones, sec_tens, min_ones, min_tens, sec_pulse, wrap_pulse
  );
endinterface

// File: rtl/minsec_counter.sv
// BCD MM:SS elapsed-time counter advanced by transitions of the blinker's square wave.
// Each counted transition emits sec_pulse; rolling MAX_MIN:59 over to 00:00 also emits wrap_pulse.
module minsec_counter #(
  parameter bit          BOTH_EDGES = 1'b1,
  parameter int unsigned MAX_MIN    = 59
) (
  input  logic              clk,
  input  logic              reset,
  minsec_counter_if.slave   bus
);

  localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

  // One BCD digit step: returns {carry, next_digit}; the digit rolls to 0 past its last value.
  function automatic logic [4:0] bcd_step(input logic [3:0] digit, input logic [3:0] last);
    logic [4:0] res;
    if (digit == last) begin
      res = {1'b1, 4'd0};
    end else begin
      res = {1'b0, digit + 4'd1};
    end
    return res;
  endfunction

  logic       tick_q, tick_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic       sec_pulse_q, sec_pulse_d;
  logic       wrap_pulse_q, wrap_pulse_d;

  logic       edge_s;
  logic       cnt_en_s;
  logic       min_at_max_s;
  logic [4:0] so_step_s;
  logic [4:0] st_step_s;
  logic [4:0] mo_step_s;

  // Edge detection and the clear > count > hold next-state ripple.
  always_comb begin
    tick_d       = bus.tick_in;
    sec_ones_d   = sec_ones_q;
    sec_tens_d   = sec_tens_q;
    min_ones_d   = min_ones_q;
    min_tens_d   = min_tens_q;
    sec_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;

    if (BOTH_EDGES) begin
      edge_s = bus.tick_in ^ tick_q;
    end else begin
      edge_s = bus.tick_in & ~tick_q;
    end
    cnt_en_s     = edge_s & bus.run & ~bus.clear;
    min_at_max_s = (min_tens_q == MAX_TENS) && (min_ones_q == MAX_ONES);
    so_step_s    = bcd_step(sec_ones_q, 4'd9);
    st_step_s    = bcd_step(sec_tens_q, 4'd5);
    mo_step_s    = bcd_step(min_ones_q, 4'd9);

    if (bus.clear) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
    end else if (cnt_en_s) begin
      sec_pulse_d = 1'b1;
      sec_ones_d  = so_step_s[3:0];
      if (so_step_s[4]) begin
        sec_tens_d = st_step_s[3:0];
        // A full minute: either wrap both minute digits or ripple into them.
        if (st_step_s[4] && min_at_max_s) begin
          min_ones_d   = 4'd0;
          min_tens_d   = 4'd0;
          wrap_pulse_d = 1'b1;
        end else if (st_step_s[4]) begin
          min_ones_d = mo_step_s[3:0];
          if (mo_step_s[4]) begin
            min_tens_d = min_tens_q + 4'd1;
          end else begin
            min_tens_d = min_tens_q;
          end
        end else begin
          min_ones_d = min_ones_q;
          min_tens_d = min_tens_q;
        end
      end else begin
        sec_tens_d = sec_tens_q;
      end
    end else begin
      sec_pulse_d  = 1'b0;
      wrap_pulse_d = 1'b0;
    end
  end

  // State registers; the tick history keeps tracking tick_in even while reset is held.
  always_ff @(posedge clk) begin
    tick_q <= tick_d;
    if (reset) begin
      sec_ones_q   <= 4'd0;
      sec_tens_q   <= 4'd0;
      min_ones_q   <= 4'd0;
      min_tens_q   <= 4'd0;
      sec_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      sec_ones_q   <= sec_ones_d;
      sec_tens_q   <= sec_tens_d;
      min_ones_q   <= min_ones_d;
      min_tens_q   <= min_tens_d;
      sec_pulse_q  <= sec_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  assign bus.sec_ones   = sec_ones_q;
  assign bus.sec_tens   = sec_tens_q;
  assign bus.min_ones   = min_ones_q;
  assign bus.min_tens   = min_tens_q;
  assign bus.sec_pulse  = sec_pulse_q;
  assign bus.wrap_pulse = wrap_pulse_q;

endmodule

// File: tb/tb_minsec_counter.sv
// Bench for minsec_counter: two instances (both-edge and rising-only) share one stimulus stream
// and are compared every cycle against an elapsed-seconds model, plus literal MM:SS checkpoints.
module tb_minsec_counter;

  localparam int PERIOD = 60 * (59 + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b1;
  logic run_i = 1'b0;
  logic clr = 1'b0;
  bit   chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  int m_total [2];
  bit m_prev  [2];
  bit m_sp    [2];
  bit m_wp    [2];
  int sp_cnt  [2];
  int wr_cnt  [2];

  minsec_counter_if bus1 ();
  minsec_counter_if bus0 ();

  assign bus1.tick_in = tick;
  assign bus1.run     = run_i;
  assign bus1.clear   = clr;
  assign bus0.tick_in = tick;
  assign bus0.run     = run_i;
  assign bus0.clear   = clr;

  minsec_counter #(.BOTH_EDGES(1'b1), .MAX_MIN(59)) dut1 (.clk(clk), .reset(rst), .bus(bus1.slave));
  minsec_counter #(.BOTH_EDGES(1'b0), .MAX_MIN(59)) dut0 (.clk(clk), .reset(rst), .bus(bus0.slave));

  always #10 clk = ~clk;

  function automatic logic [15:0] exp_digits(input int t);
    int mm;
    int ss;
    mm = t / 60;
    ss = t % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic bit counts(input int idx, input bit cur, input bit prev);
    if (idx == 1) return cur != prev;
    return cur && !prev;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: elapsed seconds modulo the MM:SS period, advanced by each accepted transition.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_prev[i] <= tick;
      if (rst || clr) begin
        m_total[i] <= 0;
        m_sp[i]    <= 1'b0;
        m_wp[i]    <= 1'b0;
      end else if (run_i && counts(i, tick, m_prev[i])) begin
        m_total[i] <= (m_total[i] + 1) % PERIOD;
        m_sp[i]    <= 1'b1;
        m_wp[i]    <= (m_total[i] == PERIOD - 1);
      end else begin
        m_sp[i] <= 1'b0;
        m_wp[i] <= 1'b0;
      end
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dig1", {bus1.min_tens, bus1.min_ones, bus1.sec_tens, bus1.sec_ones}, exp_digits(m_total[1]));
      chk("sp1", bus1.sec_pulse, m_sp[1]);
      chk("wp1", bus1.wrap_pulse, m_wp[1]);
      chk("dig0", {bus0.min_tens, bus0.min_ones, bus0.sec_tens, bus0.sec_ones}, exp_digits(m_total[0]));
      chk("sp0", bus0.sec_pulse, m_sp[0]);
      chk("wp0", bus0.wrap_pulse, m_wp[0]);
      sp_cnt[1] += int'(bus1.sec_pulse);
      wr_cnt[1] += int'(bus1.wrap_pulse);
      sp_cnt[0] += int'(bus0.sec_pulse);
      wr_cnt[0] += int'(bus0.wrap_pulse);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle();
    tick = ~tick;
    cyc(int'($urandom_range(2, 3)));
  endtask

  function automatic int d1();
    return int'({bus1.min_tens, bus1.min_ones, bus1.sec_tens, bus1.sec_ones});
  endfunction

  function automatic int d0();
    return int'({bus0.min_tens, bus0.min_ones, bus0.sec_tens, bus0.sec_ones});
  endfunction

  int sp_base1;
  int sp_base0;
  int wr_base1;

  initial begin
    for (int i = 0; i < 2; i++) begin
      sp_cnt[i] = 0;
      wr_cnt[i] = 0;
    end
    cyc(3);
    chk_en = 1'b1;
    rst = 1'b0;
    cyc(10);
    chk("reset_dig1", d1(), 16'h0000);
    chk("reset_dig0", d0(), 16'h0000);
    chk("reset_spcnt", sp_cnt[1] + sp_cnt[0], 0);

    run_i = 1'b1;
    repeat (12) toggle();
    chk("twelve_dig1", d1(), 16'h0012);
    chk("twelve_dig0", d0(), 16'h0006);
    chk("twelve_sp1", sp_cnt[1], 12);
    chk("twelve_sp0", sp_cnt[0], 6);
    chk("model_pin", m_total[1], 12);

    repeat (47) toggle();
    chk("s59_dig1", d1(), 16'h0059);
    toggle();
    chk("m1_dig1", d1(), 16'h0100);

    repeat (PERIOD - 1 - 60) toggle();
    chk("max_dig1", d1(), 16'h5959);
    wr_base1 = wr_cnt[1];
    toggle();
    chk("wrap_dig1", d1(), 16'h0000);
    chk("wrap_cnt1", wr_cnt[1] - wr_base1, 1);
    chk("half_dig0", d0(), 16'h3000);
    chk("wrap_cnt0", wr_cnt[0], 0);

    run_i = 1'b0;
    sp_base1 = sp_cnt[1];
    sp_base0 = sp_cnt[0];
    repeat (5) toggle();
    run_i = 1'b1;
    cyc(5);
    chk("hold_dig1", d1(), 16'h0000);
    chk("hold_sp1", sp_cnt[1] - sp_base1, 0);
    chk("hold_sp0", sp_cnt[0] - sp_base0, 0);

    rst = 1'b1;
    tick = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    repeat (207) toggle();
    chk("pre_clr_dig1", d1(), 16'h0327);
    chk("pre_clr_dig0", d0(), 16'h0144);
    tick = ~tick;
    clr = 1'b1;
    cyc(1);
    chk("clr_dig1", d1(), 16'h0000);
    chk("clr_dig0", d0(), 16'h0000);
    chk("clr_sp1", int'(bus1.sec_pulse), 0);
    clr = 1'b0;
    toggle();
    chk("rise_dig1", d1(), 16'h0001);
    chk("rise_dig0", d0(), 16'h0001);
    toggle();
    chk("fall_dig1", d1(), 16'h0002);
    chk("fall_dig0", d0(), 16'h0001);

    repeat (3000) begin
      if ($urandom_range(0, 2) == 0) tick = ~tick;
      run_i = ($urandom_range(0, 7) != 0);
      clr   = ($urandom_range(0, 63) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    rst = 1'b0;
    clr = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
